// File: rtl/m_store_unit_pkg.sv
// m_store_unit_pkg: shared definitions for the M-stage store issue unit.
//   - st_type encodings (ST_NONE/ST_SB/ST_SH/ST_SW)
//   - AdES exception code for the CP0 path
//   - data-memory and timer window address map
//   - FSM state encodings (IDLE/BUSY)
//   - store_range_err(): address-map legality check used when the
//     STORE_RANGE_CHK_EN macro is defined
package m_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } st_type_t;

    localparam logic [4:0]  EXC_ADES = 5'd5;

    localparam logic [31:0] DM_TOP   = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TC_SPAN  = 32'd12;
    localparam logic [31:0] TC_COUNT = 32'd8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Legal targets: data memory, or a word store to a writable timer
    // register. Timer windows are word-only and the count register
    // (offset 8) is read-only.
    function automatic logic store_range_err(input logic [31:0] addr,
                                             input logic [1:0]  st_type);
        logic [31:0] off0;
        logic [31:0] off1;
        logic        in_dm;
        logic        in_tc0;
        logic        in_tc1;
        logic        tc_bad;
        off0   = addr - TC0_BASE;
        off1   = addr - TC1_BASE;
        in_dm  = (addr <= DM_TOP);
        in_tc0 = (addr >= TC0_BASE) && (off0 < TC_SPAN);
        in_tc1 = (addr >= TC1_BASE) && (off1 < TC_SPAN);
        tc_bad = (in_tc0 && (off0 == TC_COUNT)) ||
                 (in_tc1 && (off1 == TC_COUNT)) ||
                 ((in_tc0 || in_tc1) && (st_type != ST_SW));
        return !(in_dm || in_tc0 || in_tc1) || tc_bad;
    endfunction

endpackage

// File: rtl/m_store_unit_store_lane_align.sv
// store_lane_align: combinational byte-lane steering for stores.
//   st_type    in  2   store width (ST_NONE/ST_SB/ST_SH/ST_SW)
//   addr_lo    in  2   low address bits
//   wdata      in  32  register value to store
//   data       out 32  data replicated into its byte lanes
//   byteen     out 4   byte enables
//   misaligned out 1   halfword/word not naturally aligned
module store_lane_align
    import m_store_unit_pkg::*;
(
    input  logic [1:0]  st_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] data,
    output logic [3:0]  byteen,
    output logic        misaligned
);

    always_comb begin
        data       = '0;
        byteen     = '0;
        misaligned = 1'b0;
        case (st_type)
            ST_SB: begin
                data   = {4{wdata[7:0]}};
                byteen = 4'b0001 << addr_lo;
            end
            ST_SH: begin
                data       = {2{wdata[15:0]}};
                byteen     = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            ST_SW: begin
                data       = wdata;
                byteen     = '1;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/m_store_unit.sv
// m_store_unit: M-stage store issue unit with a one-entry store buffer.
// Validates the store address, aligns data into byte lanes and presents
// the buffered store to the data bus with a req/ack handshake.
// Optional feature: define STORE_RANGE_CHK_EN to add the data-memory /
// timer window range check to the AdES condition.
//   clk, reset  clock, asynchronous active-high reset
//   st_valid    M stage holds a store
//   st_type     0 none, 1 sb, 2 sh, 3 sw
//   st_addr     byte address
//   st_wdata    forwarded rt value
//   flush       kill the incoming store
//   stall       hold M stage and upstream
//   exc_ades    AdES for the incoming store
//   bus_req     buffered store valid
//   bus_addr    word-aligned address
//   bus_wdata   lane-aligned data
//   bus_byteen  byte enables
//   bus_ack     bus consumed the request this cycle
module m_store_unit
    import m_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        exc_ades,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic        bus_ack
);

    logic [0:0]  state;
    logic [31:0] lane_data;
    logic [3:0]  lane_byteen;
    logic        misaligned;
    logic        out_of_range;
    logic        store_present;
    logic        accept;

    store_lane_align u_align (
        .st_type    (st_type),
        .addr_lo    (st_addr[1:0]),
        .wdata      (st_wdata),
        .data       (lane_data),
        .byteen     (lane_byteen),
        .misaligned (misaligned)
    );

`ifdef STORE_RANGE_CHK_EN
    assign out_of_range = store_range_err(st_addr, st_type);
`else
    assign out_of_range = 1'b0;
`endif

    assign store_present = st_valid && (st_type != ST_NONE) && !flush;
    assign exc_ades      = store_present && (misaligned || out_of_range);
    // An ack in the same cycle frees the buffer, so the new store can
    // reload it without a bubble.
    assign stall         = store_present && !exc_ades && (state == BUSY) && !bus_ack;
    assign accept        = store_present && !exc_ades && !stall;
    assign bus_req       = (state == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_byteen <= '0;
        end else if (accept) begin
            state      <= BUSY;
            bus_addr   <= {st_addr[31:2], 2'b00};
            bus_wdata  <= lane_data;
            bus_byteen <= lane_byteen;
        end else if ((state == BUSY) && bus_ack) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_m_store_unit.sv
module tb_m_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        flush;
    logic        stall;
    logic        exc_ades;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic        bus_ack;

    m_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_type    (st_type),
        .st_addr    (st_addr),
        .st_wdata   (st_wdata),
        .flush      (flush),
        .stall      (stall),
        .exc_ades   (exc_ades),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_byteen (bus_byteen),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    txn_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference address map: DM 0..0x2FFF, two 12-byte timer windows,
    // timers word-only, count register at offset 8 read-only.
    function automatic bit model_range_err(input logic [31:0] a, input int t);
        bit dm, t0, t1;
        dm = (a <= 32'h2FFF);
        t0 = (a >= 32'h7F00) && (a < 32'h7F0C);
        t1 = (a >= 32'h7F10) && (a < 32'h7F1C);
        if (!(dm || t0 || t1)) return 1'b1;
        if ((t0 || t1) && t != 3) return 1'b1;
        if (a == 32'h7F08 || a == 32'h7F18) return 1'b1;
        return 1'b0;
    endfunction

    // One pipeline cycle: drive on negedge, check combinational outputs,
    // and enqueue the expected bus transaction once the clock edge commits it.
    task automatic cyc(input bit v, input int t, input logic [31:0] a,
                       input logic [31:0] d, input bit f, input bit ack);
        bit   present, mis, oor, exp_exc, exp_stall, acc;
        txn_t e;
        @(negedge clk);
        st_valid = v;
        st_type  = 2'(t);
        st_addr  = a;
        st_wdata = d;
        flush    = f;
        bus_ack  = ack;
        #1;
        present = v && (t != 0) && !f;
        mis     = (t == 2 && (a % 2) != 0) || (t == 3 && (a % 4) != 0);
`ifdef STORE_RANGE_CHK_EN
        oor = model_range_err(a, t);
`else
        oor = 1'b0;
`endif
        exp_exc   = present && (mis || oor);
        exp_stall = present && !exp_exc && (sb_q.size() != 0) && !ack;
        acc       = present && !exp_exc && !exp_stall;
        chk("exc_ades", 32'(exc_ades), 32'(exp_exc));
        chk("stall", 32'(stall), 32'(exp_stall));
        e.addr = a - (a % 4);
        case (t)
            1: begin e.data = (d & 32'hFF) * 32'h0101_0101;   e.be = 4'(1 << (a % 4)); end
            2: begin e.data = (d & 32'hFFFF) * 32'h0001_0001; e.be = ((a % 4) >= 2) ? 4'hC : 4'h3; end
            default: begin e.data = d; e.be = 4'hF; end
        endcase
        @(posedge clk);
        #1;
        if (acc) sb_q.push_back(e);
    endtask

    // Monitor: samples late in each cycle, after inputs settle and before
    // the next edge; compares the presented store with the queue head.
    initial begin
        txn_t h;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                chk("bus_req", 32'(bus_req), 32'(sb_q.size() != 0));
                if (bus_req && sb_q.size() != 0) begin
                    h = sb_q[0];
                    chk("bus_addr", bus_addr, h.addr);
                    chk("bus_wdata", bus_wdata, h.data);
                    chk("bus_byteen", 32'(bus_byteen), 32'(h.be));
                    if (bus_ack) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a;
        int t;
        reset = 1'b1;
        st_valid = 0; st_type = 0; st_addr = 0; st_wdata = 0; flush = 0; bus_ack = 0;
        #12;
        chk("reset_bus_req", 32'(bus_req), 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_bus_wdata", bus_wdata, 32'd0);
        chk("reset_bus_byteen", 32'(bus_byteen), 32'd0);
        #10;
        reset = 1'b0;
        mon_en = 1'b1;

        // Basic sw, then ack
        cyc(1, 3, 32'h10, 32'h1234_5678, 0, 0);
        chk("sw_req", 32'(bus_req), 32'd1);
        chk("sw_wdata", bus_wdata, 32'h1234_5678);
        cyc(0, 0, 0, 0, 0, 1);
        chk("sw_req_drop", 32'(bus_req), 32'd0);
        // sb / sh lane steering
        cyc(1, 1, 32'h13, 32'hAB, 0, 0);
        chk("sb_byteen", 32'(bus_byteen), 32'h8);
        chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
        cyc(1, 2, 32'h22, 32'hBEEF, 0, 1);
        chk("sh_byteen", 32'(bus_byteen), 32'hC);
        chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        cyc(0, 0, 0, 0, 0, 1);
        // Misaligned sh, timer count register, ack while idle
        cyc(1, 2, 32'h21, 32'h1, 0, 1);
        cyc(1, 3, 32'h7F08, 32'h55, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        // Back-to-back with 3 stall cycles, then same-cycle ack+reload
        cyc(1, 3, 32'h40, 32'hA0A0_0001, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 3, 32'h44, 32'hB0B0_0002, 0, 0);
        cyc(1, 3, 32'h44, 32'hB0B0_0002, 0, 1);
        chk("reload_req", 32'(bus_req), 32'd1);
        chk("reload_addr", bus_addr, 32'h44);
        cyc(0, 0, 0, 0, 0, 1);
        // Flush while idle
        cyc(1, 3, 32'h80, 32'h77, 1, 0);
        // Async reset while busy
        cyc(1, 3, 32'h84, 32'h88, 0, 0);
        @(negedge clk);
        st_valid = 0;
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1 chk("async_reset_req", 32'(bus_req), 32'd0);
        sb_q.delete();
        #3 reset = 1'b0;
        mon_en = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(3))
                0: a = $urandom_range(32'h3100);
                1: a = 32'h7F00 + $urandom_range(15);
                2: a = 32'h7F10 + $urandom_range(15);
                default: a = $urandom;
            endcase
            t = $urandom_range(3);
            cyc(($urandom_range(3) != 0), t, a, $urandom,
                ($urandom_range(7) == 0), $urandom_range(1) == 1);
        end

        // Drain with a bounded budget
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            cyc(0, 0, 0, 0, 0, 1);
            n++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
